bcd_encoder_year: RTL and testbench
===================================

Name: bcd_encoder_year

Overview:
- Sequential BCD-to-binary converter for the year field. Inverse of the year binary-to-BCD display decoder.
- Takes three BCD digits (hundreds, tens, ones), typically from the year-setting digit-entry logic. Produces the 10-bit binary year loaded into the year counter.
- Start/busy/done handshake with fixed 3-edge latency. Flags invalid digits and out-of-range results.

Parameters:
- MAX_YEAR, 999, largest legal result. A result above this sets err and leaves dout unchanged. Legal range 0..999.

Ports:
- clk  in  1  system clock, rising-edge active
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request conversion. Sampled only in IDLE.
- bcd_hundred  in  4  hundreds digit, sampled at the start edge
- bcd_ten  in  4  tens digit, sampled at the start edge
- bcd_one  in  4  ones digit, sampled at the start edge
- dout  out  10  binary result. Updated only on a successful conversion, held otherwise.
- busy  out  1  high while a conversion is in progress
- done  out  1  single-cycle pulse when a conversion completes
- err  out  1  status of the last completed conversion (1 = rejected). Held until the next done.

Behaviour:
- Clock and reset:
  - One clock domain. All outputs are registered.
  - Reset is synchronous and active-low. rst_n=0 at a rising edge forces state=IDLE, dout=0, busy=0, done=0, err=0, and clears internal acc and flags.
  - Reset wins over every other event, including mid-conversion. The aborted conversion produces no done.
- States and transitions (2-bit encoding):
  - IDLE: if start=1, latch bcd_ten and bcd_one into holding regs; acc<=bcd_hundred (zero-extended); bad<=(any input digit>9); busy<=1; go to S_TEN. If start=0, stay in IDLE.
  - S_TEN: acc<=acc*10+ten_reg; go to S_ONE.
  - S_ONE:
    - fin = acc*10+one_reg.
    - If bad=0 and fin<=MAX_YEAR: dout<=fin, err<=0.
    - Otherwise: dout unchanged, err<=1.
    - In both cases: done<=1, busy<=0, go to IDLE.
- done is high for exactly one cycle, then clears on the next edge unless reset.
- Latency:
  - The start edge is E0. busy is high after E0 and after E1.
  - done and the new dout/err are visible after E2.
  - Next start is accepted at E3 at the earliest (back-to-back throughput: one conversion per 3 cycles).
- Arithmetic:
  - acc*10 is implemented as (acc<<3)+(acc<<1), no multiplier.
  - acc and the sum are 10 bits, truncated modulo 1024. With valid digits the maximum is 999, so no overflow occurs.
  - With invalid digits truncation may occur; the result is discarded via bad.
- Boundary conditions:
  - start while busy: ignored, with no effect on the in-flight conversion.
  - start held high continuously: a new conversion starts on each IDLE edge, i.e. at E3, E6, ...
  - Input digits changing after E0: no effect.
  - All-zero digits: dout=0, err=0.
  - Digit value 10..15 in any position: err=1, dout keeps its previous value.
  - Result greater than MAX_YEAR with all digits valid: err=1, dout keeps its previous value.

Test Plan:
- Reset, then start with digits 2,0,2 -> busy=1 for 2 cycles; after E2, done=1 for 1 cycle, dout=202, err=0.
- Digits 9,9,9 then 0,0,0 back-to-back, start held high -> done after E2 with dout=999, then done after E5 with dout=0. Both have err=0.
- After dout=202, digits 1,12,5 -> done after E2 with err=1, dout stays 202. Next valid 0,4,7 -> dout=47, err=0.
- MAX_YEAR=500, digits 5,0,1 -> err=1, dout unchanged. Digits 5,0,0 -> dout=500, err=0.
- start pulsed again at E1 with digits 3,3,3 during a 1,2,3 conversion -> ignored. Result dout=123, one done pulse only. Inputs changed after E0 are also ignored.
- rst_n=0 at E1 of a 7,7,7 conversion -> after that edge: busy=0, done=0, dout=0, err=0. No done follows; the next start converts normally.

Source files
------------

// File: rtl/bcd_encoder_year.sv
// rtl/bcd_encoder_year.sv - sequential three-digit BCD to 10-bit binary year converter
module bcd_encoder_year #(
   parameter int MAX_YEAR = 999
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] bcd_hundred,
   input  logic [3:0] bcd_ten,
   input  logic [3:0] bcd_one,
   output logic [9:0] dout,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      S_TEN = 2'd1,
      S_ONE = 2'd2
   } state_t;

   localparam logic [9:0] MAX_Y = MAX_YEAR[9:0];

   state_t     state;
   state_t     state_nx;
   logic [3:0] ten_reg;
   logic [3:0] one_reg;
   logic [9:0] acc;
   logic       bad;

   logic [9:0] acc_x10;
   logic [3:0] addend;
   logic [9:0] step_sum;
   logic       fin_ok;
   logic       any_bad;

   // One multiply-by-ten-and-add step shared by S_TEN and S_ONE; shifts replace a multiplier
   always_comb begin
      acc_x10  = (acc << 3) + (acc << 1);
      addend   = (state == S_TEN) ? ten_reg : one_reg;
      step_sum = acc_x10 + {6'd0, addend};
      fin_ok   = !bad && (step_sum <= MAX_Y);
      any_bad  = (bcd_hundred > 4'd9) || (bcd_ten > 4'd9) || (bcd_one > 4'd9);
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic: start is only honoured in IDLE, the two digit steps always advance
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = S_TEN;
         S_TEN:   state_nx = S_ONE;
         S_ONE:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath and registered outputs; digits are captured once at the start edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ten_reg <= 4'd0;
         one_reg <= 4'd0;
         acc     <= 10'd0;
         bad     <= 1'b0;
         dout    <= 10'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  ten_reg <= bcd_ten;
                  one_reg <= bcd_one;
                  acc     <= {6'd0, bcd_hundred};
                  bad     <= any_bad;
                  busy    <= 1'b1;
               end
            end
            S_TEN: begin
               acc <= step_sum;
            end
            S_ONE: begin
               if (fin_ok) begin
                  dout <= step_sum;
                  err  <= 1'b0;
               end else begin
                  err  <= 1'b1;
               end
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_encoder_year.sv
// tb/tb_bcd_encoder_year.sv - scoreboard bench for bcd_encoder_year at MAX_YEAR 999 and 500
module tb_bcd_encoder_year;

   typedef struct {
      int         exp_cyc;
      logic [9:0] dout;
      logic       err;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] bcd_hundred;
   logic [3:0] bcd_ten;
   logic [3:0] bcd_one;
   logic [9:0] dout_w [2];
   logic       busy_w [2];
   logic       done_w [2];
   logic       err_w  [2];

   int         max_y [2] = '{999, 500};
   logic [9:0] last_dout [2];
   exp_t       q [2][$];
   int         cyc = 0;
   int         total = 0;
   int         errors = 0;

   bcd_encoder_year #(.MAX_YEAR(999)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start),
      .bcd_hundred(bcd_hundred), .bcd_ten(bcd_ten), .bcd_one(bcd_one),
      .dout(dout_w[0]), .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0])
   );

   bcd_encoder_year #(.MAX_YEAR(500)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start),
      .bcd_hundred(bcd_hundred), .bcd_ten(bcd_ten), .bcd_one(bcd_one),
      .dout(dout_w[1]), .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      total = total + 1;
      if (act != req) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: the year is the decimal value of the digits; rejected results keep the old value
   function automatic exp_t model(input int h, input int t, input int o,
                                  input int maxv, input logic [9:0] last, input int ecyc);
      exp_t r;
      int   v;
      v         = h * 100 + t * 10 + o;
      r.exp_cyc = ecyc;
      if (h > 9 || t > 9 || o > 9 || v > maxv) begin
         r.dout = last;
         r.err  = 1'b1;
      end else begin
         r.dout = v[9:0];
         r.err  = 1'b0;
      end
      return r;
   endfunction

   // Monitor: compare every done pulse against the queue head, and flag missing or spurious pulses
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 2; k++) begin
            if (done_w[k]) begin
               if (q[k].size() == 0) begin
                  chk($sformatf("unexpected_done[%0d]", k), 1, 0);
               end else begin
                  exp_t e;
                  e = q[k].pop_front();
                  chk($sformatf("done_cycle[%0d]", k), cyc, e.exp_cyc);
                  chk($sformatf("dout[%0d]", k), int'(dout_w[k]), int'(e.dout));
                  chk($sformatf("err[%0d]", k), int'(err_w[k]), int'(e.err));
                  chk($sformatf("busy_at_done[%0d]", k), int'(busy_w[k]), 0);
               end
            end else if (q[k].size() != 0 && cyc >= q[k][0].exp_cyc) begin
               exp_t e;
               e = q[k].pop_front();
               chk($sformatf("missing_done[%0d]", k), 0, 1);
            end
         end
      end
   end

   function automatic logic [3:0] rand_digit();
      if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
      return 4'($urandom_range(0, 9));
   endfunction

   // mode 0: single start pulse; 1: start held high with junk digits; 2: extra start with 3,3,3 at E1
   task automatic issue(input int h, input int t, input int o, input int mode);
      @(negedge clk);
      start       = 1'b1;
      bcd_hundred = 4'(h);
      bcd_ten     = 4'(t);
      bcd_one     = 4'(o);
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         exp_t e;
         e = model(h, t, o, max_y[k], last_dout[k], cyc + 2);
         last_dout[k] = e.dout;
         q[k].push_back(e);
         chk($sformatf("busy_e0[%0d]", k), int'(busy_w[k]), 1);
      end
      if (mode == 0) begin
         start = 1'b0;
      end else if (mode == 1) begin
         bcd_hundred = rand_digit();
         bcd_ten     = rand_digit();
         bcd_one     = rand_digit();
      end else begin
         bcd_hundred = 4'd3;
         bcd_ten     = 4'd3;
         bcd_one     = 4'd3;
      end
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk($sformatf("busy_e1[%0d]", k), int'(busy_w[k]), 1);
      if (mode == 1) begin
         bcd_hundred = rand_digit();
         bcd_ten     = rand_digit();
      end else begin
         start = 1'b0;
      end
      @(posedge clk);
   endtask

   task automatic check_cleared(input string tag);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s_busy[%0d]", tag, k), int'(busy_w[k]), 0);
         chk($sformatf("%s_done[%0d]", tag, k), int'(done_w[k]), 0);
         chk($sformatf("%s_dout[%0d]", tag, k), int'(dout_w[k]), 0);
         chk($sformatf("%s_err[%0d]", tag, k), int'(err_w[k]), 0);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      bcd_hundred = 4'd0;
      bcd_ten     = 4'd0;
      bcd_one     = 4'd0;
      last_dout   = '{10'd0, 10'd0};
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_cleared("reset");
      rst_n = 1'b1;

      issue(2, 0, 2, 0);
      @(negedge clk);
      issue(9, 9, 9, 1);
      issue(0, 0, 0, 0);
      issue(2, 0, 2, 0);
      issue(1, 12, 5, 0);
      issue(0, 4, 7, 0);
      issue(5, 0, 1, 0);
      issue(5, 0, 0, 0);
      issue(1, 2, 3, 2);
      issue(15, 9, 9, 0);
      issue(9, 9, 10, 0);

      // Reset one edge after the start of a 7,7,7 conversion: nothing may complete
      @(negedge clk);
      start       = 1'b1;
      bcd_hundred = 4'd7;
      bcd_ten     = 4'd7;
      bcd_one     = 4'd7;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_cleared("midreset");
      last_dout = '{10'd0, 10'd0};
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      issue(1, 9, 9, 0);

      for (int i = 0; i < 60; i++) begin
         issue(int'(rand_digit()), int'(rand_digit()), int'(rand_digit()),
               int'($urandom_range(0, 2)));
      end

      start = 1'b0;
      repeat (6) @(negedge clk);
      for (int k = 0; k < 2; k++) chk($sformatf("queue_drained[%0d]", k), q[k].size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, total);
      $finish;
   end

endmodule
